// File: rtl/mosfet_stream_calc.sv
// mosfet_stream_calc: streaming MOSFET current/gm calculator with a running descending
// insertion sort and a weighted result over the three largest or three smallest values.
module mosfet_stream_calc #(
    parameter int N_DEV = 6,
    parameter int VW    = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [1:0]      mode,
    input  logic [VW-1:0]   W,
    input  logic [VW-1:0]   V_GS,
    input  logic [VW-1:0]   V_DS,
    output logic            out_valid,
    output logic [3*VW-2:0] out_n
);
    localparam int OW = 3*VW-1;
    localparam int IW = 3*VW+1;
    localparam int SW = 3*VW+3;
    localparam int CW = $clog2(N_DEV+1);
    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, OUT} state_t;
    state_t state;
    logic [CW-1:0] cnt;
    logic [1:0] mode_q;
    logic drain_d, val_v, acc, m0, triode;
    logic [OW-1:0] val_q, dev, n0, n1, n2, res;
    logic [OW-1:0] lst [N_DEV];
    logic [OW-1:0] nxt [N_DEV];
    logic [N_DEV-1:0] ge;
    logic [IW-1:0] vov, vds, num;
    logic [SW-1:0] sum3, wsum;
    always_comb begin
        acc = in_valid && (state == IDLE || state == LOAD);
        m0 = (state == IDLE) ? mode[0] : mode_q[0];
        vds = IW'(V_DS);
        vov = (V_GS != '0) ? IW'(V_GS) - IW'(1) : '0;
        triode = vov > vds;
        num = m0 ? (triode ? ((vov * vds) << 1) - vds * vds : vov * vov)
                 : (triode ? vds << 1 : vov << 1);
        dev = (vov == '0) ? '0 : OW'(IW'(W) * num / IW'(3));
    end
    // New value lands after every entry >= it, so equal values keep arrival order.
    always_comb begin
        for (int i = 0; i < N_DEV; i++) ge[i] = lst[i] >= val_q;
        nxt[0] = ge[0] ? lst[0] : val_q;
        for (int i = 1; i < N_DEV; i++) nxt[i] = ge[i] ? lst[i] : (ge[i-1] ? val_q : lst[i-1]);
    end
    always_comb begin
        sum3 = SW'(n0) + SW'(n1) + SW'(n2);
        wsum = SW'(n0) * SW'(3) + SW'(n1) * SW'(4) + SW'(n2) * SW'(5);
        res = mode_q[0] ? OW'(wsum / SW'(12)) : OW'(sum3 / SW'(3));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            mode_q <= '0;
            drain_d <= 1'b0;
            val_v <= 1'b0;
            val_q <= '0;
            n0 <= '0;
            n1 <= '0;
            n2 <= '0;
            out_valid <= 1'b0;
            out_n <= '0;
            for (int i = 0; i < N_DEV; i++) lst[i] <= '0;
        end else begin
            val_v <= acc;
            if (acc) val_q <= dev;
            if (state == IDLE && in_valid) begin
                for (int i = 0; i < N_DEV; i++) lst[i] <= '0;
            end else if (val_v) begin
                for (int i = 0; i < N_DEV; i++) lst[i] <= nxt[i];
            end
            // The last insert settles one edge into DRAIN; capture the selection on the next.
            if (state == DRAIN && drain_d) begin
                n0 <= mode_q[1] ? lst[0] : lst[N_DEV-3];
                n1 <= mode_q[1] ? lst[1] : lst[N_DEV-2];
                n2 <= mode_q[1] ? lst[2] : lst[N_DEV-1];
            end
            out_valid <= state == OUT;
            out_n <= (state == OUT) ? res : '0;
            case (state)
                IDLE: if (in_valid) begin
                    state <= LOAD;
                    cnt <= CW'(1);
                    mode_q <= mode;
                end
                LOAD: if (in_valid) begin
                    cnt <= (cnt == CW'(N_DEV-1)) ? '0 : cnt + CW'(1);
                    if (cnt == CW'(N_DEV-1)) state <= DRAIN;
                end
                DRAIN: begin
                    drain_d <= !drain_d;
                    if (drain_d) state <= OUT;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mosfet_stream_calc.sv
// tb_mosfet_stream_calc: directed frames against two parameterisations of the stream calculator.
module tb_mosfet_stream_calc;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;
    logic in_valid6 = 1'b0, ov6;
    logic [1:0] mode6 = '0;
    logic [2:0] w6 = '0, g6 = '0, s6 = '0;
    logic [7:0] on6;
    logic in_valid3 = 1'b0, ov3;
    logic [1:0] mode3 = '0;
    logic [3:0] w3 = '0, g3 = '0, s3 = '0;
    logic [10:0] on3;
    int checks = 0;
    int failures = 0;
    logic [8:0] sat [6];
    logic [8:0] mix [6];

    mosfet_stream_calc #(.N_DEV(6), .VW(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid6), .mode(mode6),
        .W(w6), .V_GS(g6), .V_DS(s6), .out_valid(ov6), .out_n(on6));
    mosfet_stream_calc #(.N_DEV(3), .VW(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .mode(mode3),
        .W(w3), .V_GS(g3), .V_DS(s3), .out_valid(ov3), .out_n(on3));

    task automatic load6(input logic [8:0] d [6], input logic [1:0] m, input int ga, input int gb,
                         input int gl, output logic bad);
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ov6 !== 1'b0 || on6 !== '0) bad = 1'b1;
            in_valid6 = 1'b1; mode6 = m;
            w6 = d[i][8:6]; g6 = d[i][5:3]; s6 = d[i][2:0];
            if (i == ga || i == gb)
                for (int j = 0; j < gl; j++) begin
                    @(negedge clk);
                    if (ov6 !== 1'b0 || on6 !== '0) bad = 1'b1;
                    in_valid6 = 1'b0; w6 = 3'd7; g6 = 3'd7; s6 = 3'd7;
                end
        end
    endtask

    // lat counts clock edges from the last accepted device to the edge that raises out_valid.
    task automatic obs6(input logic hold, output int lat, output logic [7:0] val, output int width,
                        output logic leak);
        lat = -1; val = '0; width = 0; leak = 1'b0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            @(negedge clk);
            if (ov6 === 1'b1) begin lat = k - 1; val = on6; width = 1; end
            else if (on6 !== '0) leak = 1'b1;
            in_valid6 = hold && lat < 0;
            if (in_valid6) begin
                w6 = 3'($urandom); g6 = 3'($urandom); s6 = 3'($urandom); mode6 = 2'($urandom);
            end
        end
        @(negedge clk);
        if (ov6 === 1'b1) width++;
        else if (on6 !== '0) leak = 1'b1;
    endtask

    task automatic test_reset;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid6 = 1'b1; w6 = 3'd7; g6 = 3'd7; s6 = 3'd7; mode6 = 2'd3;
            checks++;
            if (ov6 !== 1'b0 || on6 !== '0 || ov3 !== 1'b0 || on3 !== '0) begin
                failures++;
                $display("FAIL reset_hold: ov6=%b on6=%0d ov3=%b on3=%0d required all 0", ov6, on6, ov3, on3);
            end
        end
        in_valid6 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (ov6 !== 1'b0 || on6 !== '0 || ov3 !== 1'b0 || on3 !== '0) begin
                failures++;
                $display("FAIL reset_idle: ov6=%b on6=%0d ov3=%b on3=%0d required all 0", ov6, on6, ov3, on3);
            end
        end
    endtask

    task automatic test_saturation;
        logic [1:0] m [2] = '{2'd3, 2'd0};
        logic [7:0] e [2] = '{8'd84, 8'd28};
        int lat, width;
        logic [7:0] val;
        logic bad, leak;
        for (int t = 0; t < 2; t++) begin
            load6(sat, m[t], -1, -1, 0, bad);
            obs6(1'b0, lat, val, width, leak);
            checks++;
            if (val !== e[t]) begin
                failures++;
                $display("FAIL sat_value mode=%0d: got %0d required %0d", m[t], val, e[t]);
            end
            checks++;
            if (lat !== 3 || width !== 1) begin
                failures++;
                $display("FAIL sat_timing mode=%0d: latency %0d width %0d required 3 and 1", m[t], lat, width);
            end
            checks++;
            if (bad !== 1'b0 || leak !== 1'b0) begin
                failures++;
                $display("FAIL sat_quiet mode=%0d: load_bad=%b leak=%b required 0", m[t], bad, leak);
            end
        end
    endtask

    task automatic test_mixed;
        logic [1:0] m [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
        logic [7:0] e [4] = '{8'd54, 8'd3, 8'd20, 8'd1};
        int lat, width;
        logic [7:0] val;
        logic bad, leak;
        for (int t = 0; t < 4; t++) begin
            load6(mix, m[t], -1, -1, 0, bad);
            obs6(1'b0, lat, val, width, leak);
            checks++;
            if (val !== e[t] || lat !== 3) begin
                failures++;
                $display("FAIL mixed mode=%0d: got %0d latency %0d required %0d latency 3", m[t], val, lat, e[t]);
            end
        end
    endtask

    task automatic test_bubbles;
        int lat, width;
        logic [7:0] val;
        logic bad, leak;
        load6(mix, 2'd3, 1, 4, 2, bad);
        obs6(1'b0, lat, val, width, leak);
        checks++;
        if (val !== 8'd54) begin
            failures++;
            $display("FAIL bubble_value: got %0d required 54", val);
        end
        checks++;
        if (lat !== 3 || width !== 1) begin
            failures++;
            $display("FAIL bubble_timing: latency %0d width %0d required 3 and 1", lat, width);
        end
        checks++;
        if (bad !== 1'b0 || leak !== 1'b0) begin
            failures++;
            $display("FAIL bubble_quiet: load_bad=%b leak=%b required 0", bad, leak);
        end
    endtask

    task automatic test_busy;
        int lat, width;
        logic [7:0] val;
        logic bad, leak;
        load6(mix, 2'd2, -1, -1, 0, bad);
        obs6(1'b1, lat, val, width, leak);
        checks++;
        if (val !== 8'd20 || lat !== 3 || width !== 1) begin
            failures++;
            $display("FAIL busy_value: got %0d latency %0d width %0d required 20 3 1", val, lat, width);
        end
        load6(sat, 2'd0, -1, -1, 0, bad);
        obs6(1'b0, lat, val, width, leak);
        checks++;
        if (val !== 8'd28 || lat !== 3 || bad !== 1'b0) begin
            failures++;
            $display("FAIL busy_next: got %0d latency %0d load_bad=%b required 28 3 0", val, lat, bad);
        end
    endtask

    task automatic test_reset_mid;
        int lat, width;
        logic [7:0] val;
        logic bad, leak, seen;
        load6(sat, 2'd3, -1, -1, 0, bad);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            in_valid6 = 1'b0;
            seen = ov6;
        end
        checks++;
        if (seen !== 1'b1 || on6 !== 8'd84) begin
            failures++;
            $display("FAIL pre_reset_pulse: seen=%b out=%0d required 1 and 84", seen, on6);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ov6 !== 1'b0 || on6 !== '0) begin
            failures++;
            $display("FAIL reset_async_out: ov=%b out=%0d required 0 0", ov6, on6);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid6 = 1'b1; mode6 = 2'd3;
            w6 = mix[i][8:6]; g6 = mix[i][5:3]; s6 = mix[i][2:0];
        end
        @(negedge clk);
        in_valid6 = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (ov6 !== 1'b0 || on6 !== '0) begin
            failures++;
            $display("FAIL reset_mid_out: ov=%b out=%0d required 0 0", ov6, on6);
        end
        #2 rst_n = 1'b1;
        load6(mix, 2'd1, -1, -1, 0, bad);
        obs6(1'b0, lat, val, width, leak);
        checks++;
        if (val !== 8'd3 || lat !== 3 || width !== 1) begin
            failures++;
            $display("FAIL reset_recover: got %0d latency %0d width %0d required 3 3 1", val, lat, width);
        end
    endtask

    // (15,15,15) gives saturation current 15*14*14/3 = 980 and gm 2*15*14/3 = 140; the others give 0.
    task automatic test_sweep;
        logic [11:0] d [3] = '{12'hFFF, 12'h120, 12'h000};
        logic [1:0] m [3] = '{2'd3, 2'd1, 2'd2};
        logic [10:0] e [3] = '{11'd245, 11'd245, 11'd46};
        logic [10:0] val;
        int lat;
        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                in_valid3 = 1'b1; mode3 = m[t];
                w3 = d[i][11:8]; g3 = d[i][7:4]; s3 = d[i][3:0];
            end
            lat = -1; val = '0;
            for (int k = 1; k <= 12 && lat < 0; k++) begin
                @(negedge clk);
                in_valid3 = 1'b0;
                if (ov3 === 1'b1) begin lat = k - 1; val = on3; end
            end
            @(negedge clk);
            checks++;
            if (val !== e[t] || lat !== 3 || ov3 !== 1'b0) begin
                failures++;
                $display("FAIL sweep mode=%0d: got %0d latency %0d trailing_valid=%b required %0d 3 0",
                         m[t], val, lat, ov3, e[t]);
            end
        end
    endtask

    initial begin
        sat = '{9'o777, 9'o777, 9'o777, 9'o777, 9'o777, 9'o777};
        mix = '{9'o777, 9'o352, 9'o113, 9'o352, 9'o205, 9'o777};
        test_reset;
        test_saturation;
        test_mixed;
        test_bubbles;
        test_busy;
        test_reset_mid;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
